// File: rtl/commit_bank_arbiter_pkg.sv
// Shared writeback/commit types and the ROB bank helper, used by the arbiter and the ROB.
package commit_bank_arbiter_pkg;

    localparam int PREG_W       = 6;
    localparam int DATA_W       = 64;
    localparam int COMMIT_WIDTH = 2;
    localparam int BANK_W       = (COMMIT_WIDTH > 1) ? $clog2(COMMIT_WIDTH) : 1;

    typedef logic [PREG_W-1:0] preg_addr_t;
    typedef logic [DATA_W-1:0] word_t;

    typedef struct packed {
        preg_addr_t dst;
        word_t      data;
    } wb_req_t;

    // The ROB result RAM is banked on the low preg bits.
    function automatic logic [BANK_W-1:0] bank(input preg_addr_t dst);
        if (COMMIT_WIDTH > 1) return dst[BANK_W-1:0];
        return '0;
    endfunction

endpackage

// File: rtl/commit_bank_arbiter_if.sv
// FU writeback side and ROB commit side of the commit bank arbiter.
interface commit_bank_arbiter_if
    import commit_bank_arbiter_pkg::*;
#(
    parameter int FU_NUM = 4
) ();

    logic       [FU_NUM-1:0]       fu_valid;
    logic       [FU_NUM-1:0]       fu_ready;
    preg_addr_t [FU_NUM-1:0]       fu_dst;
    word_t      [FU_NUM-1:0]       fu_data;

    logic       [COMMIT_WIDTH-1:0] cm_valid;
    preg_addr_t [COMMIT_WIDTH-1:0] cm_dst;
    word_t      [COMMIT_WIDTH-1:0] cm_data;

    modport master (
        output fu_valid, fu_dst, fu_data,
        input  fu_ready, cm_valid, cm_dst, cm_data
    );

    modport slave (
        input  fu_valid, fu_dst, fu_data,
        output fu_ready, cm_valid, cm_dst, cm_data
    );

endinterface

// File: rtl/commit_bank_arbiter_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after ptr, wrapping modulo N.
module commit_bank_arbiter_rr_arbiter #(
    parameter  int N     = 4,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx
);

    int   idx;
    logic found;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                gnt_idx  = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/commit_bank_arbiter.sv
// Buffers FU writebacks in per-FU skid FIFOs and schedules FIFO heads onto the banked ROB commit ports.
module commit_bank_arbiter
    import commit_bank_arbiter_pkg::*;
#(
    parameter int FU_NUM = 4,
    parameter int DEPTH  = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    commit_bank_arbiter_if.slave  bus
);

    localparam int FU_W  = (FU_NUM > 1) ? $clog2(FU_NUM) : 1;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    wb_req_t          mem   [FU_NUM][DEPTH];
    logic [PTR_W-1:0] head  [FU_NUM];
    logic [PTR_W-1:0] tail  [FU_NUM];
    logic [CNT_W-1:0] count [FU_NUM];
    logic [FU_W-1:0]  rr    [COMMIT_WIDTH];

    wb_req_t           head_req [FU_NUM];
    logic [FU_NUM-1:0] not_empty;
    logic [FU_NUM-1:0] ready;
    logic [FU_NUM-1:0] push;
    logic [FU_NUM-1:0] pop;
    logic [FU_NUM-1:0] req     [COMMIT_WIDTH];
    logic [FU_NUM-1:0] gnt     [COMMIT_WIDTH];
    logic [FU_W-1:0]   gnt_idx [COMMIT_WIDTH];

    logic       [COMMIT_WIDTH-1:0] cm_valid_q;
    preg_addr_t [COMMIT_WIDTH-1:0] cm_dst_q;
    word_t      [COMMIT_WIDTH-1:0] cm_data_q;

    // Ready depends only on occupancy: a full FIFO never accepts, even if its head pops this cycle.
    always_comb begin
        for (int i = 0; i < FU_NUM; i++) begin
            head_req[i]  = mem[i][head[i]];
            not_empty[i] = (count[i] != '0);
            ready[i]     = (count[i] != CNT_W'(DEPTH));
        end
    end

    assign push = bus.fu_valid & ready;

    always_comb begin
        for (int b = 0; b < COMMIT_WIDTH; b++) begin
            for (int i = 0; i < FU_NUM; i++) begin
                req[b][i] = not_empty[i] && (bank(head_req[i].dst) == BANK_W'(b));
            end
        end
    end

    always_comb begin
        pop = '0;
        for (int b = 0; b < COMMIT_WIDTH; b++) begin
            pop = pop | gnt[b];
        end
    end

    for (genvar b = 0; b < COMMIT_WIDTH; b++) begin : g_bank
        commit_bank_arbiter_rr_arbiter #(.N(FU_NUM)) u_arb (
            .req     (req[b]),
            .ptr     (rr[b]),
            .gnt     (gnt[b]),
            .gnt_idx (gnt_idx[b])
        );

        a_cm_bank: assert property (@(posedge clk) disable iff (reset)
            cm_valid_q[b] |-> (bank(cm_dst_q[b]) == BANK_W'(b)));
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < FU_NUM; i++) begin
            if (push[i] && !flush && !reset) begin
                mem[i][tail[i]] <= '{dst: bus.fu_dst[i], data: bus.fu_data[i]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < FU_NUM; i++) begin
                head[i]  <= '0;
                tail[i]  <= '0;
                count[i] <= '0;
            end
            for (int b = 0; b < COMMIT_WIDTH; b++) begin
                rr[b] <= '0;
            end
            cm_valid_q <= '0;
            cm_dst_q   <= '0;
            cm_data_q  <= '0;
        end else if (flush) begin
            // Pushes and grants of the flush cycle are dropped; arbitration fairness survives.
            for (int i = 0; i < FU_NUM; i++) begin
                head[i]  <= '0;
                tail[i]  <= '0;
                count[i] <= '0;
            end
            cm_valid_q <= '0;
        end else begin
            for (int i = 0; i < FU_NUM; i++) begin
                if (push[i]) tail[i] <= tail[i] + 1'b1;
                if (pop[i])  head[i] <= head[i] + 1'b1;
                count[i] <= count[i] + CNT_W'(push[i]) - CNT_W'(pop[i]);
            end
            for (int b = 0; b < COMMIT_WIDTH; b++) begin
                cm_valid_q[b] <= |gnt[b];
                if (|gnt[b]) begin
                    cm_dst_q[b]  <= head_req[gnt_idx[b]].dst;
                    cm_data_q[b] <= head_req[gnt_idx[b]].data;
                    rr[b]        <= (gnt_idx[b] == FU_W'(FU_NUM - 1)) ? '0 : gnt_idx[b] + 1'b1;
                end
            end
        end
    end

    assign bus.fu_ready = ready;
    assign bus.cm_valid = cm_valid_q;
    assign bus.cm_dst   = cm_dst_q;
    assign bus.cm_data  = cm_data_q;

    a_push_when_full: assert property (@(posedge clk) disable iff (reset)
        (bus.fu_valid & ~ready) == '0);

endmodule

// File: tb/tb_commit_bank_arbiter.sv
// Directed and random stimulus against a queue-based reference model; a negedge monitor scores every commit port.
module tb_commit_bank_arbiter;
    import commit_bank_arbiter_pkg::*;

    localparam int FU_NUM = 4;
    localparam int DEPTH  = 2;

    logic clk;
    logic reset;
    logic flush;

    commit_bank_arbiter_if #(.FU_NUM(FU_NUM)) bus ();

    commit_bank_arbiter #(.FU_NUM(FU_NUM), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: per-FU result queues, per-bank round-robin pointer, per-port expected outputs.
    wb_req_t mq [FU_NUM][$];
    wb_req_t eq [COMMIT_WIDTH][$];
    int      mrr [COMMIT_WIDTH];

    function automatic logic [FU_NUM-1:0] model_ready();
        logic [FU_NUM-1:0] r;
        for (int i = 0; i < FU_NUM; i++) r[i] = (mq[i].size() < DEPTH);
        return r;
    endfunction

    function automatic bit model_busy();
        bit busy = 1'b0;
        for (int i = 0; i < FU_NUM; i++) if (mq[i].size() != 0) busy = 1'b1;
        for (int b = 0; b < COMMIT_WIDTH; b++) if (eq[b].size() != 0) busy = 1'b1;
        return busy;
    endfunction

    always @(posedge clk) begin
        int                g [COMMIT_WIDTH];
        int                fi;
        logic [FU_NUM-1:0] rdy;
        if (reset) begin
            for (int i = 0; i < FU_NUM; i++) mq[i].delete();
            for (int b = 0; b < COMMIT_WIDTH; b++) mrr[b] = 0;
        end else begin
            for (int i = 0; i < FU_NUM; i++) rdy[i] = (mq[i].size() < DEPTH);
            for (int b = 0; b < COMMIT_WIDTH; b++) begin
                g[b] = -1;
                for (int k = 0; k < FU_NUM; k++) begin
                    fi = (mrr[b] + k) % FU_NUM;
                    if (g[b] < 0 && mq[fi].size() > 0 && (int'(mq[fi][0].dst) % COMMIT_WIDTH) == b)
                        g[b] = fi;
                end
            end
            if (flush) begin
                for (int i = 0; i < FU_NUM; i++) mq[i].delete();
            end else begin
                for (int b = 0; b < COMMIT_WIDTH; b++) begin
                    if (g[b] >= 0) begin
                        eq[b].push_back(mq[g[b]].pop_front());
                        mrr[b] = (g[b] + 1) % FU_NUM;
                    end
                end
                for (int i = 0; i < FU_NUM; i++) begin
                    if (bus.fu_valid[i] && rdy[i])
                        mq[i].push_back('{dst: bus.fu_dst[i], data: bus.fu_data[i]});
                end
            end
        end
    end

    always @(negedge clk) begin
        wb_req_t e;
        for (int b = 0; b < COMMIT_WIDTH; b++) begin
            n_vec++;
            if (bus.cm_valid[b] !== 1'b0) begin
                if (eq[b].size() == 0) begin
                    n_err++;
                    $display("FAIL port%0d_spurious: got valid=%b dst=%0h, expected no output",
                             b, bus.cm_valid[b], bus.cm_dst[b]);
                end else begin
                    e = eq[b].pop_front();
                    if (bus.cm_dst[b] !== e.dst || bus.cm_data[b] !== e.data) begin
                        n_err++;
                        $display("FAIL port%0d_payload: got dst=%0h data=%0h, expected dst=%0h data=%0h",
                                 b, bus.cm_dst[b], bus.cm_data[b], e.dst, e.data);
                    end
                end
            end else if (eq[b].size() != 0) begin
                e = eq[b].pop_front();
                n_err++;
                $display("FAIL port%0d_missing: got valid=0, expected dst=%0h data=%0h", b, e.dst, e.data);
            end
        end
        n_vec++;
        if (bus.fu_ready !== model_ready()) begin
            n_err++;
            $display("FAIL fu_ready: got %b, expected %b", bus.fu_ready, model_ready());
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic set_fu(input int i, input int dst, input logic [63:0] data);
        bus.fu_valid[i] = 1'b1;
        bus.fu_dst[i]   = PREG_W'(dst);
        bus.fu_data[i]  = data;
    endtask

    // Applies the current inputs across one rising edge, then clears them.
    task automatic tick();
        bus.fu_valid = bus.fu_valid & model_ready();
        @(negedge clk);
        bus.fu_valid = '0;
        flush        = 1'b0;
    endtask

    task automatic apply_reset();
        reset        = 1'b1;
        flush        = 1'b0;
        bus.fu_valid = '0;
        repeat (3) begin
            @(negedge clk);
            check("reset_cm_valid", 64'(bus.cm_valid), 64'h0);
        end
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        reset        = 1'b1;
        flush        = 1'b0;
        bus.fu_valid = '0;
        bus.fu_dst   = '0;
        bus.fu_data  = '0;

        // Reset, then idle.
        apply_reset();
        tick();
        check("idle_fu_ready", 64'(bus.fu_ready), 64'hF);
        check("idle_cm_valid", 64'(bus.cm_valid), 64'h0);
        tick();

        // Single push: two-cycle latency, no bypass.
        set_fu(0, 'h04, 64'hA);
        tick();
        check("t2_no_bypass", 64'(bus.cm_valid), 64'h0);
        tick();
        check("t2_cm_valid", 64'(bus.cm_valid), 64'h1);
        check("t2_cm_dst0", 64'(bus.cm_dst[0]), 64'h04);
        check("t2_cm_data0", bus.cm_data[0], 64'hA);

        // Two banks in the same cycle.
        set_fu(0, 'h02, 64'h22);
        set_fu(1, 'h07, 64'h77);
        tick();
        tick();
        check("t3_cm_valid", 64'(bus.cm_valid), 64'h3);
        check("t3_cm_dst0", 64'(bus.cm_dst[0]), 64'h02);
        check("t3_cm_dst1", 64'(bus.cm_dst[1]), 64'h07);

        // Four FUs competing for bank 0.
        apply_reset();
        for (int i = 0; i < FU_NUM; i++) set_fu(i, 2 * i, 64'h100 + 64'(i));
        tick();
        for (int k = 0; k < FU_NUM; k++) begin
            tick();
            check("t4_cm_valid", 64'(bus.cm_valid), 64'h1);
            check("t4_order", 64'(bus.cm_dst[0]), 64'(2 * k));
        end
        set_fu(0, 'h08, 64'h8);
        tick();
        tick();
        set_fu(0, 'h0A, 64'hA0);
        set_fu(1, 'h0C, 64'hC1);
        tick();
        tick();
        check("t4_rr_fu1_first", 64'(bus.cm_dst[0]), 64'h0C);
        tick();
        check("t4_rr_fu0_next", 64'(bus.cm_dst[0]), 64'h0A);
        tick();

        // FU2 backs up while FU3 holds bank-1 priority.
        apply_reset();
        set_fu(2, 'h01, 64'h1);
        tick();
        tick();
        set_fu(2, 'h11, 64'h211);
        set_fu(3, 'h21, 64'h321);
        tick();
        set_fu(2, 'h13, 64'h213);
        tick();
        check("t5_fu3_first", 64'(bus.cm_dst[1]), 64'h21);
        check("t5_fu_ready2_low", 64'(bus.fu_ready[2]), 64'h0);
        tick();
        check("t5_first", 64'(bus.cm_dst[1]), 64'h11);
        set_fu(2, 'h15, 64'h215);
        tick();
        check("t5_second", 64'(bus.cm_dst[1]), 64'h13);
        tick();
        check("t5_third", 64'(bus.cm_dst[1]), 64'h15);
        tick();

        // Flush with queued entries and a grant in flight.
        apply_reset();
        set_fu(0, 'h00, 64'h0);
        tick();
        tick();
        set_fu(0, 'h10, 64'h10);
        set_fu(1, 'h12, 64'h12);
        tick();
        set_fu(0, 'h14, 64'h14);
        tick();
        check("t6_pre_flush", 64'(bus.cm_dst[0]), 64'h12);
        flush = 1'b1;
        set_fu(2, 'h30, 64'h30);
        tick();
        check("t6_flush_cm_valid", 64'(bus.cm_valid), 64'h0);
        check("t6_flush_fu_ready", 64'(bus.fu_ready), 64'hF);
        repeat (5) tick();

        // Random traffic with occasional flush and reset.
        for (int c = 0; c < 500; c++) begin
            for (int i = 0; i < FU_NUM; i++) begin
                if ($urandom_range(0, 1) == 1)
                    set_fu(i, int'($urandom_range(0, 63)), {$urandom, $urandom});
            end
            flush = ($urandom_range(0, 31) == 0);
            reset = ($urandom_range(0, 199) == 0);
            tick();
            reset = 1'b0;
        end

        t = 0;
        while (model_busy() && t < 100) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        @(negedge clk);
        n_vec++;
        if (model_busy()) begin
            n_err++;
            $display("FAIL drain: got outstanding results, expected all committed");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
